// File: rtl/sram_sched_pkg.sv
// Shared types for the SRAM slot scheduler and its write-queue producer.
package sram_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAP,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } sched_state_t;

    function automatic int addr_w(input int y_w, input int x_w);
        return y_w + x_w;
    endfunction

    localparam int DEF_DATA_W = 8;
    localparam int DEF_X_W    = 9;
    localparam int DEF_Y_W    = 8;
    localparam int DEF_ADDR_W = addr_w(DEF_Y_W, DEF_X_W);

    // Layout of one pending-write FIFO word: {address, data}.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_DATA_W-1:0] data;
    } write_req_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit counter that sticks at 16'hFFFF; only built with SRAM_SCHED_STATS_EN,
// where it backs the writesDone / slotsRun statistics.
`ifdef SRAM_SCHED_STATS_EN
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

endmodule
`endif

// File: rtl/sram_slot_scheduler.sv
// Slot-based async SRAM owner: READS_PER_SLOT scanout reads, then up to
// WRITES_PER_SLOT queued writes per slotStart. Optional SRAM_SCHED_STATS_EN adds counters.
module sram_slot_scheduler
    import sram_sched_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int X_W             = 9,
    parameter int Y_W             = 8,
    parameter int READS_PER_SLOT  = 2,
    parameter int WRITES_PER_SLOT = 1,
    localparam int ADDR_W         = addr_w(Y_W, X_W)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             slotStart,
    input  logic [X_W-1:0]                   readXCoord,
    input  logic [Y_W-1:0]                   readYCoord,
    output logic [READS_PER_SLOT*DATA_W-1:0] pixels,
    output logic                             pixelsValid,
    output logic                             busy,
    output logic                             overrun,
`ifdef SRAM_SCHED_STATS_EN
    output logic [15:0]                      writesDone,
    output logic [15:0]                      slotsRun,
`endif
    input  logic [ADDR_W+DATA_W-1:0]         writeQueueData,
    input  logic                             writeQueueEmpty,
    output logic                             writeQueueRead,
    output logic [ADDR_W-1:0]                sramAddress,
    inout  wire  [DATA_W-1:0]                sramData,
    output logic                             outputEnableN,
    output logic                             writeEnableN
);

    localparam int RD_W = (READS_PER_SLOT > 1) ? $clog2(READS_PER_SLOT) : 1;
    localparam int WC_W = 3;

    sched_state_t                      state;
    logic [X_W-1:0]                    x0;
    logic [Y_W-1:0]                    y_lat;
    logic [RD_W-1:0]                   rd_idx;
    logic [WC_W-1:0]                   wr_cnt;
    logic [DATA_W-1:0]                 wr_data;
    logic                              write_drive;
    logic [READS_PER_SLOT*DATA_W-1:0]  cap_buf;
    logic [READS_PER_SLOT*DATA_W-1:0]  cap_next;
    logic [X_W-1:0]                    rd_x_next;
    logic                              last_rd;
    logic                              more_writes;
    logic                              decide;

    assign sramData    = write_drive ? wr_data : {DATA_W{1'bz}};
    assign last_rd     = (rd_idx == RD_W'(READS_PER_SLOT - 1));
    assign more_writes = (int'(wr_cnt) < WRITES_PER_SLOT) && !writeQueueEmpty;
    assign decide      = (state == RD_CAP && last_rd) || (state == WR_HOLD);
    // x wraps within the row; it never carries into y.
    assign rd_x_next   = x0 + X_W'(rd_idx) + X_W'(1);

    // Pixels are assembled in a shadow buffer so `pixels` changes atomically.
    always_comb begin
        cap_next = cap_buf;
        cap_next[rd_idx*DATA_W +: DATA_W] = sramData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pixels         <= '0;
            cap_buf        <= '0;
            pixelsValid    <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            writeQueueRead <= 1'b0;
            sramAddress    <= '0;
            writeEnableN   <= 1'b1;
            outputEnableN  <= 1'b1;
            write_drive    <= 1'b0;
            wr_data        <= '0;
            x0             <= '0;
            y_lat          <= '0;
            rd_idx         <= '0;
            wr_cnt         <= '0;
        end else begin
            pixelsValid    <= 1'b0;
            writeQueueRead <= 1'b0;
            if (slotStart && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    outputEnableN <= 1'b1;
                    if (slotStart) begin
                        x0            <= readXCoord;
                        y_lat         <= readYCoord;
                        rd_idx        <= '0;
                        wr_cnt        <= '0;
                        busy          <= 1'b1;
                        sramAddress   <= {readYCoord, readXCoord};
                        outputEnableN <= 1'b0;
                        state         <= RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    cap_buf <= cap_next;
                    if (!last_rd) begin
                        rd_idx      <= rd_idx + RD_W'(1);
                        sramAddress <= {y_lat, rd_x_next};
                        state       <= RD_ADDR;
                    end else begin
                        pixels        <= cap_next;
                        pixelsValid   <= 1'b1;
                        outputEnableN <= 1'b1;
                    end
                end
                WR_SETUP: begin
                    writeEnableN <= 1'b0;
                    state        <= WR_STROBE;
                end
                WR_STROBE: begin
                    writeEnableN <= 1'b1;
                    wr_cnt       <= wr_cnt + WC_W'(1);
                    state        <= WR_HOLD;
                end
                WR_HOLD: begin
                end
                default: state <= IDLE;
            endcase

            // Shared exit from the last read capture and from each write hold.
            if (decide) begin
                if (more_writes) begin
                    state          <= WR_SETUP;
                    sramAddress    <= writeQueueData[DATA_W +: ADDR_W];
                    wr_data        <= writeQueueData[DATA_W-1:0];
                    write_drive    <= 1'b1;
                    writeQueueRead <= 1'b1;
                    outputEnableN  <= 1'b1;
                end else begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    write_drive <= 1'b0;
                end
            end
        end
    end

    a_oe_we_excl: assert property (@(posedge clock) disable iff (!reset)
        !(!outputEnableN && !writeEnableN));
    a_no_drive_on_read: assert property (@(posedge clock) disable iff (!reset)
        !(write_drive && !outputEnableN));

`ifdef SRAM_SCHED_STATS_EN
    logic slot_done;
    assign slot_done = decide && !more_writes;

    sat_counter16 u_writes_done (
        .clk   (clock),
        .rst_n (reset),
        .inc   (state == WR_HOLD),
        .count (writesDone)
    );

    sat_counter16 u_slots_run (
        .clk   (clock),
        .rst_n (reset),
        .inc   (slot_done),
        .count (slotsRun)
    );
`endif

endmodule

// File: tb/tb_sram_slot_scheduler.sv
// Scoreboard bench for sram_slot_scheduler: async SRAM model, show-ahead FIFO
// model, pixel and write monitors fed by expectation queues.
module tb_sram_slot_scheduler;
    import sram_sched_pkg::*;

    localparam int DATA_W = 8;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int R      = 2;
    localparam int W      = 2;
    localparam int ADDR_W = X_W + Y_W;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic                     slotStart = 1'b0;
    logic [X_W-1:0]           readXCoord = '0;
    logic [Y_W-1:0]           readYCoord = '0;
    logic [R*DATA_W-1:0]      pixels;
    logic                     pixelsValid;
    logic                     busy;
    logic                     overrun;
    logic [ADDR_W+DATA_W-1:0] writeQueueData = '0;
    logic                     writeQueueEmpty = 1'b1;
    logic                     writeQueueRead;
    logic [ADDR_W-1:0]        sramAddress;
    wire  [DATA_W-1:0]        sramData;
    logic                     outputEnableN;
    logic                     writeEnableN;

    sram_slot_scheduler #(
        .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W),
        .READS_PER_SLOT(R), .WRITES_PER_SLOT(W)
    ) dut (
        .clock(clock), .reset(reset), .slotStart(slotStart),
        .readXCoord(readXCoord), .readYCoord(readYCoord),
        .pixels(pixels), .pixelsValid(pixelsValid), .busy(busy), .overrun(overrun),
        .writeQueueData(writeQueueData), .writeQueueEmpty(writeQueueEmpty),
        .writeQueueRead(writeQueueRead), .sramAddress(sramAddress), .sramData(sramData),
        .outputEnableN(outputEnableN), .writeEnableN(writeEnableN)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int bus_viol = 0;
    int rd_pulses = 0;

    logic [DATA_W-1:0]        mem [0:(1<<ADDR_W)-1];
    write_req_t               fq[$];
    logic [R*DATA_W-1:0]      pix_q[$];
    logic [ADDR_W+DATA_W-1:0] wr_q[$];
    logic                     prev_we_low = 1'b0;

    // Async SRAM: drives on OE# low (WE# high), stores on WE# rising edge.
    assign sramData = (!outputEnableN && writeEnableN) ? mem[sramAddress] : {DATA_W{1'bz}};
    always @(posedge writeEnableN) if (reset) mem[sramAddress] = sramData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && writeQueueRead) begin
            rd_pulses++;
            if (fq.size() > 0) void'(fq.pop_front());
        end
        writeQueueEmpty = (fq.size() == 0);
        writeQueueData  = (fq.size() > 0) ? fq[0] : '0;
    end

    always @(negedge clock) begin
        if (reset && pixelsValid) begin
            if (pix_q.size() == 0) chk("pix_unexpected", pixels, 'x);
            else chk("pixels", pixels, pix_q.pop_front());
        end
    end

    always @(negedge clock) begin
        if (reset && !writeEnableN) begin
            if (prev_we_low) chk("we_width", 2, 1);
            else if (wr_q.size() == 0) chk("wr_unexpected", {sramAddress, sramData}, 'x);
            else chk("wr_addr_data", {sramAddress, sramData}, wr_q.pop_front());
            prev_we_low = 1'b1;
        end else begin
            prev_we_low = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            if (!outputEnableN && !writeEnableN) bus_viol++;
            if (!outputEnableN && $isunknown(sramData)) bus_viol++;
        end
    end

    function automatic logic [R*DATA_W-1:0] exp_pix(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [X_W-1:0] x1;
        x1 = x + 1'b1;
        return {mem[{y, x1}], mem[{y, x}]};
    endfunction

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit expect_wr);
        write_req_t e;
        e.address = a;
        e.data    = d;
        fq.push_back(e);
        if (expect_wr) wr_q.push_back({a, d});
    endtask

    // Cycle 0 carries slotStart; lat is the cycle pixelsValid is seen, len the busy cycles.
    task automatic run_slot(input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input int ovr_at,
                            output int lat, output int len);
        lat = -1;
        len = -1;
        @(negedge clock);
        readXCoord = x;
        readYCoord = y;
        slotStart  = 1'b1;
        @(posedge clock); #1;
        slotStart = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (pixelsValid && lat < 0) lat = c;
            if (!busy && len < 0) len = c - 1;
            if (len >= 0 && c > ovr_at) break;
            slotStart = (c == ovr_at);
            @(posedge clock); #1;
        end
        slotStart = 1'b0;
        if (len < 0) chk("slot_timeout_busy", busy, 0);
    endtask

    task automatic check_reset_state(input string tag);
        logic [DATA_W-1:0] zbus;
        zbus = {DATA_W{1'bz}};
        chk({tag, "_pixels"}, pixels, 0);
        chk({tag, "_valid"}, pixelsValid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_qread"}, writeQueueRead, 0);
        chk({tag, "_addr"}, sramAddress, 0);
        chk({tag, "_we_n"}, writeEnableN, 1);
        chk({tag, "_oe_n"}, outputEnableN, 1);
        chk({tag, "_data_z"}, sramData, zbus);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int lat, len, rd0, n_exp;
        logic [X_W-1:0] rx;
        logic [Y_W-1:0] ry;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i ^ (i >> 7));
        mem[{8'd3, 9'd10}]  = 8'hA5;
        mem[{8'd3, 9'd11}]  = 8'h5A;
        mem[{8'd7, 9'd511}] = 8'h11;
        mem[{8'd7, 9'd0}]   = 8'h22;
        mem[{8'd8, 9'd0}]   = 8'hEE;
        mem[{8'd5, 9'd20}]  = 8'h01;
        mem[{8'd5, 9'd21}]  = 8'h02;
        mem[{8'd6, 9'd30}]  = 8'h33;
        mem[{8'd6, 9'd31}]  = 8'h44;

        repeat (3) @(negedge clock);
        check_reset_state("rst");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic read, then x wrap at the row end.
        pix_q.push_back(16'h5AA5);
        run_slot(9'd10, 8'd3, 0, lat, len);
        chk("basic_latency", lat, 5);
        chk("basic_len", len, 4);
        chk("basic_no_qread", rd_pulses, 0);

        pix_q.push_back(16'h2211);
        run_slot(9'd511, 8'd7, 0, lat, len);
        chk("wrap_len", len, 4);

        // Three queued writes, two serviced per slot.
        push_wr(17'h00100, 8'h3C, 1);
        push_wr(17'h00201, 8'hC3, 1);
        push_wr(17'h1FFFF, 8'h77, 1);
        rd0 = rd_pulses;
        pix_q.push_back(16'h0201);
        run_slot(9'd20, 8'd5, 0, lat, len);
        chk("drain_len", len, 10);
        chk("drain_latency", lat, 5);
        chk("drain_qreads", rd_pulses - rd0, 2);
        chk("drain_left", fq.size(), 1);
        chk("drain_mem0", mem[17'h00100], 8'h3C);
        chk("drain_mem1", mem[17'h00201], 8'hC3);

        rd0 = rd_pulses;
        pix_q.push_back(16'h4433);
        run_slot(9'd30, 8'd6, 0, lat, len);
        chk("tail_len", len, 7);
        chk("tail_qreads", rd_pulses - rd0, 1);
        chk("tail_mem", mem[17'h1FFFF], 8'h77);

        // Overrun two cycles into a slot.
        chk("overrun_clear", overrun, 0);
        pix_q.push_back(16'h5AA5);
        run_slot(9'd10, 8'd3, 2, lat, len);
        chk("overrun_set", overrun, 1);
        chk("overrun_len", len, 4);
        pix_q.push_back(exp_pix(9'd40, 8'd9));
        run_slot(9'd40, 8'd9, 0, lat, len);
        chk("overrun_sticky", overrun, 1);

        // Async reset while WE# is low.
        push_wr(17'h0AAAA, 8'h99, 0);
        rd0 = rd_pulses;
        pix_q.push_back(exp_pix(9'd50, 8'd2));
        @(negedge clock);
        readXCoord = 9'd50;
        readYCoord = 8'd2;
        slotStart  = 1'b1;
        @(posedge clock); #1;
        slotStart = 1'b0;
        for (int c = 1; c <= 20 && writeEnableN; c++) begin
            @(posedge clock); #1;
        end
        chk("strobe_reached", writeEnableN, 0);
        #1 reset = 1'b0;
        #1;
        check_reset_state("strobe_rst");
        chk("strobe_popped", rd_pulses - rd0, 1);
        #4 reset = 1'b1;
        pix_q.push_back(16'h5AA5);
        run_slot(9'd10, 8'd3, 0, lat, len);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_len", len, 4);
        chk("post_rst_overrun", overrun, 0);

        // slotStart on the cycle the slot returns to IDLE is ignored.
        pix_q.push_back(exp_pix(9'd60, 8'd4));
        run_slot(9'd60, 8'd4, 4, lat, len);
        chk("edge_overrun", overrun, 1);
        chk("edge_len", len, 4);
        @(posedge clock); #1;
        chk("edge_not_started", busy, 0);

        // Random slots and queue traffic.
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) push_wr(17'($urandom), 8'($urandom), 1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
            rx = 9'($urandom);
            ry = 8'($urandom);
            n_exp = (fq.size() < W) ? fq.size() : W;
            pix_q.push_back(exp_pix(rx, ry));
            run_slot(rx, ry, 0, lat, len);
            chk("rand_len", len, 4 + 3 * n_exp);
        end
        for (int t = 0; t < 20 && fq.size() > 0; t++) begin
            pix_q.push_back(exp_pix(9'd5, 8'd5));
            run_slot(9'd5, 8'd5, 0, lat, len);
        end
        repeat (3) @(negedge clock);

        chk("fifo_drained", fq.size(), 0);
        chk("pix_q_empty", pix_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("bus_safety", bus_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
